// File: rtl/regfile_bank.sv
// MIPS register file storage: 32 x WIDTH registers, hard-wired $zero, pending-write scoreboard.
// Optional same-cycle write-through enabled by defining REGFILE_BYPASS_EN.
module regfile_bank #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREG  = 32
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    We,
    input  logic [4:0]              Waddr,
    input  logic [WIDTH-1:0]        Wdata,
    input  logic                    Rsv_En,
    input  logic [4:0]              Rsv_Addr,
    input  logic [4:0]              Rs_Addr,
    input  logic [4:0]              Rt_Addr,
    output logic [NREG*WIDTH-1:0]   Regs_Out,
    output logic [NREG-1:0]         Busy_Vec,
    output logic                    Rs_Busy,
    output logic                    Rt_Busy
);

    localparam int unsigned AW = 5;

    logic [WIDTH-1:0] r_regs [NREG];
    logic [NREG-1:0]  r_busy;
    logic [NREG-1:0]  w_busy_nxt;
    logic [NREG-1:0]  w_busy_view;
    logic             w_wr;
    logic             w_rsv;

    assign w_wr  = We && (Waddr != '0);
    assign w_rsv = Rsv_En && (Rsv_Addr != '0);

    // Write clears the pending flag; a same-cycle reserve is the newer producer and wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr) begin
            w_busy_nxt[Waddr] = 1'b0;
        end
        if (w_rsv) begin
            w_busy_nxt[Rsv_Addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr) begin
                r_regs[Waddr] <= Wdata;
            end
            r_busy <= w_busy_nxt;
        end
    end

    // Flat register bus feeding the downstream read multiplexers; slice 0 is $zero.
    for (genvar k = 0; k < int'(NREG); k++) begin : g_out
        if (k == 0) begin : g_zero
            assign Regs_Out[k*WIDTH +: WIDTH] = '0;
        end else begin : g_reg
`ifdef REGFILE_BYPASS_EN
            assign Regs_Out[k*WIDTH +: WIDTH] = (We && (Waddr == AW'(k))) ? Wdata : r_regs[k];
`else
            assign Regs_Out[k*WIDTH +: WIDTH] = r_regs[k];
`endif
        end
    end

    // Busy view used for operand lookup; bypass lets a same-cycle write-back clear it.
    always_comb begin
        w_busy_view = r_busy;
`ifdef REGFILE_BYPASS_EN
        if (w_wr) begin
            w_busy_view[Waddr] = w_rsv && (Rsv_Addr == Waddr);
        end
`endif
        w_busy_view[0] = 1'b0;
    end

    assign Busy_Vec = r_busy;
    assign Rs_Busy  = (Rs_Addr != '0) && w_busy_view[Rs_Addr];
    assign Rt_Busy  = (Rt_Addr != '0) && w_busy_view[Rt_Addr];

endmodule
